// File: rtl/magnetron_cmd_pkg.sv
// ----------------------------------------------------------------------------
// magnetron_cmd_pkg
//   Shared types and defaults for the magnetron command conditioner.
//   - state_t       : cook-cycle FSM encoding (IDLE / SETTING / RUNNING)
//   - DB_CYCLES_DEF : default debounce length in clk samples
//   - PULSE_LEN_DEF : default width of the latch set pulse in clk cycles
// ----------------------------------------------------------------------------
package magnetron_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SETTING = 2'b01,
        RUNNING = 2'b10
    } state_t;

    localparam int DB_CYCLES_DEF = 4;
    localparam int PULSE_LEN_DEF = 2;

endpackage

// File: rtl/magnetron_cmd_conditioner_debounce_sync.sv
// ----------------------------------------------------------------------------
// debounce_sync
//   Two-flop synchroniser followed by a counting debouncer for one raw,
//   asynchronous panel input.
//   Ports:
//     clk   in  system clock, rising edge
//     rst   in  asynchronous active-high reset
//     raw   in  raw asynchronous input
//     level out debounced, synchronous level (0 after reset)
//   A new level is accepted only after DB_CYCLES consecutive synchronised
//   samples that differ from the current level; any equal sample restarts
//   the count, so glitches shorter than DB_CYCLES samples are ignored.
// ----------------------------------------------------------------------------
module debounce_sync #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DB_CYCLES);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // Synchroniser chain plus the differing-sample counter that gates level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                // This is the DB_CYCLES-th differing sample in a row.
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/magnetron_cmd_conditioner.sv
// ----------------------------------------------------------------------------
// magnetron_cmd_conditioner
//   Front end for the oven's on/off SR latch. Conditions the raw panel keys
//   and door switch, qualifies start presses, and drives the latch's
//   active-low set/reset inputs so that reset always wins.
//   Ports:
//     clk            in  system clock, rising edge
//     rst            in  asynchronous active-high reset
//     start_btn      in  raw start key, 1 = pressed
//     stop_btn       in  raw stop/cancel key, 1 = pressed
//     door_closed    in  raw door switch, 1 = closed
//     timer_done     in  countdown expired, synchronous level
//     set_n          out latch S drive, active low
//     reset_n        out latch R drive, active low
//     running        out 1 while a cook cycle is accepted
//     start_rejected out one-cycle pulse when a start press is refused
// ----------------------------------------------------------------------------
module magnetron_cmd_conditioner
    import magnetron_cmd_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int PULSE_LEN = PULSE_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start_btn,
    input  logic stop_btn,
    input  logic door_closed,
    input  logic timer_done,
    output logic set_n,
    output logic reset_n,
    output logic running,
    output logic start_rejected
);

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    logic          start_db;
    logic          stop_db;
    logic          door_db;
    logic          start_prev;
    logic          start_event;
    logic          rc;
    logic [PW-1:0] pulse_cnt;
    state_t        state;

    debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_start_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (start_btn),
        .level (start_db)
    );

    debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_stop_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (stop_btn),
        .level (stop_db)
    );

    // Door debounces to 0 after reset, so the oven starts out treating the
    // door as open until a closed level has been seen long enough.
    debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_door_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (door_closed),
        .level (door_db)
    );

    // Anything that must switch the magnetron off; timer_done is already
    // synchronous and is used raw so expiry acts on the very next edge.
    assign rc          = stop_db | ~door_db | timer_done;
    assign start_event = start_db & ~start_prev;

    // Cook-cycle FSM. reset_n is refreshed from rc in every state, and every
    // branch that sees rc=1 also releases set_n on the same edge, which is
    // what keeps set_n and reset_n from ever being low together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            set_n          <= 1'b1;
            reset_n        <= 1'b0;
            running        <= 1'b0;
            start_rejected <= 1'b0;
            start_prev     <= 1'b0;
            pulse_cnt      <= '0;
        end else begin
            start_prev     <= start_db;
            reset_n        <= ~rc;
            start_rejected <= 1'b0;
            case (state)
                IDLE: begin
                    set_n <= 1'b1;
                    if (start_event) begin
                        if (rc) begin
                            start_rejected <= 1'b1;
                        end else begin
                            state     <= SETTING;
                            running   <= 1'b1;
                            set_n     <= 1'b0;
                            pulse_cnt <= PW'(PULSE_LEN - 1);
                        end
                    end
                end
                SETTING: begin
                    if (rc) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        set_n   <= 1'b1;
                    end else if (pulse_cnt == '0) begin
                        state <= RUNNING;
                        set_n <= 1'b1;
                    end else begin
                        pulse_cnt <= pulse_cnt - 1'b1;
                    end
                end
                RUNNING: begin
                    // Further start presses are deliberately ignored here.
                    set_n <= 1'b1;
                    if (rc) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    set_n   <= 1'b1;
                end
            endcase
        end
    end

endmodule
